// File: rtl/gcd_engine.sv
// Multi-cycle subtractive Euclidean GCD core with a start/ready/done handshake.
// Optional macro GCD_EARLY_ONE_EN: finish as soon as either operand reaches 1.
module gcd_engine #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             coprime
);

    // StLoad is a single settle cycle after the operands are captured; it is
    // seen from outside as part of RUN (ready=0, done=0).
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             run_done;
    logic [WIDTH-1:0] run_res;

    // Terminal checks for the current operands, in priority order.
    always_comb begin
        run_done = 1'b1;
        run_res  = a_q;
`ifdef GCD_EARLY_ONE_EN
        if (a_q == WIDTH'(1) || b_q == WIDTH'(1)) begin
            run_res = WIDTH'(1);
        end else
`endif
        if (a_q == '0) begin
            run_res = b_q;
        end else if (b_q == '0) begin
            run_res = a_q;
        end else if (a_q == b_q) begin
            run_res = a_q;
        end else begin
            run_done = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            coprime <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        result  <= '0;
                        coprime <= 1'b0;
                        done    <= 1'b0;
                        ready   <= 1'b0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (run_done) begin
                        result  <= run_res;
                        coprime <= (run_res == WIDTH'(1));
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        state_q <= StDone;
                    end else if (a_q > b_q) begin
                        a_q <= a_q - b_q;
                    end else begin
                        b_q <= b_q - a_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed-vector bench for gcd_engine: results, coprime flag, latency, abort and back-to-back.
module tb_gcd_engine;

    localparam int unsigned WIDTH = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             coprime;

    int n_vec = 0;
    int n_err = 0;

    gcd_engine #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .coprime(coprime)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Call #1 after an edge. Start is sampled at the next edge (E0); latency is
    // the number of edges from E0 until done is seen high.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int exp_res, input int exp_cop, input int exp_lat,
                          input bit hold);
        int n;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) start = 1'b0;
        // Operand changes while busy must not be picked up.
        op_a = 16'd35;
        op_b = 16'd21;
        check($sformatf("%s ready_busy", tag), {31'd0, ready}, 32'd0);
        check($sformatf("%s done_clr", tag), {31'd0, done}, 32'd0);
        n = 0;
        while (!done && n < exp_lat + 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        start = 1'b0;
        check($sformatf("%s latency", tag), n, exp_lat);
        check($sformatf("%s result", tag), {16'd0, result}, exp_res);
        check($sformatf("%s coprime", tag), {31'd0, coprime}, exp_cop);
        check($sformatf("%s ready_done", tag), {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // Reset held for two cycles.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst ready", {31'd0, ready}, 32'd1);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", {16'd0, result}, 32'd0);
        check("rst coprime", {31'd0, coprime}, 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Start held high through RUN: ignored, operands not re-sampled.
        run_op("g12_18", 16'd12, 16'd18, 6, 0, 4, 1'b1);
`ifdef GCD_EARLY_ONE_EN
        run_op("g25534_3", 16'd25534, 16'd3, 1, 1, 8513, 1'b0);
`else
        run_op("g25534_3", 16'd25534, 16'd3, 1, 1, 8515, 1'b0);
`endif
        run_op("g25534_2", 16'd25534, 16'd2, 2, 0, 12768, 1'b0);
        run_op("g0_0", 16'd0, 16'd0, 0, 0, 2, 1'b0);
        run_op("g0_9", 16'd0, 16'd9, 9, 0, 2, 1'b0);
        run_op("g9_0", 16'd9, 16'd0, 9, 0, 2, 1'b0);
        run_op("gmax", 16'hFFFF, 16'hFFFF, 65535, 0, 2, 1'b0);
`ifdef GCD_EARLY_ONE_EN
        run_op("g1_40000", 16'd1, 16'd40000, 1, 1, 2, 1'b0);
        run_op("g1_5", 16'd1, 16'd5, 1, 1, 2, 1'b0);
`else
        run_op("g1_5", 16'd1, 16'd5, 1, 1, 6, 1'b0);
`endif

        // Abort: reset three cycles into a long run.
        op_a  = 16'd25534;
        op_b  = 16'd3;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("abort ready", {31'd0, ready}, 32'd1);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", {16'd0, result}, 32'd0);
        RST = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        check("abort idle_done", {31'd0, done}, 32'd0);
        check("abort idle_ready", {31'd0, ready}, 32'd1);

        // Back-to-back: new start issued in the cycle done rises.
        run_op("b2b 7_7", 16'd7, 16'd7, 7, 0, 2, 1'b0);
        run_op("b2b 12_18", 16'd12, 16'd18, 6, 0, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Multi-cycle 16-bit Euclidean GCD core (subtractive algorithm), with a start/ready/done handshake.
- Sits directly upstream of the relprime controller. The controller issues (n, m) pairs with m = 2, 3, 4, … and consumes `result` and `coprime` to decide whether m is the answer.
- Performs one subtract/compare step per clock.

Parameters:
- WIDTH, 16, operand and result width in bits.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- op_a  input  WIDTH  first operand (the relprime n, e.g. 25534).
- op_b  input  WIDTH  second operand (candidate m).
- ready  output  1  engine can accept start (state IDLE or DONE).
- done  output  1  result valid; held high in DONE.
- result  output  WIDTH  gcd(op_a, op_b); held until next accepted start.
- coprime  output  1  result == 1; valid while done=1.

Behaviour:
- Reset (RST high at a clock edge, regardless of state): state=IDLE, ready=1, done=0, result=0, coprime=0, internal a/b=0. Reset mid-computation aborts it; no result is produced.
- States:
  - IDLE: ready=1, done=0.
  - RUN: ready=0, done=0.
  - DONE: ready=1, done=1.
- IDLE or DONE with start=1:
  - latch a<=op_a, b<=op_b; go to RUN.
  - clear done, result and coprime in the same edge.
- start while in RUN: ignored; operands are not re-sampled.
- RUN, one action per cycle, checked in this priority:
  1. a==0: result<=b, go to DONE.
  2. b==0: result<=a, go to DONE.
  3. a==b: result<=a, go to DONE.
  4. a>b: a<=a-b, stay in RUN.
  5. otherwise: b<=b-a, stay in RUN.
- Subtraction is unsigned WIDTH-bit. Underflow cannot occur because the larger operand is always the minuend.
- coprime<=1 exactly when the registered result is 1; it is updated on the same edge as result.
- Latency:
  - start sampled at edge E0; RUN occupies k+1 cycles, where k = number of subtraction steps.
  - done rises at edge E0+k+2.
  - The zero and equal-operand cases have k=0, so done rises at E0+2.
- Boundary cases:
  - gcd(0,0): result 0, coprime 0.
  - gcd(0,x) and gcd(x,0): result x.
  - Maximum operands 0xFFFF are handled; worst case k is about 2^WIDTH.
- A start accepted in DONE gives back-to-back operation: done drops on the accept edge, so there are no gaps beyond the latency.

Optional Feature:
- Macro: GCD_EARLY_ONE_EN.
- Enabled: RUN gains a priority-0 check. If a==1 or b==1, then result<=1, coprime<=1, go to DONE. This shortens coprime searches.
- Disabled: no such check. Results are identical either way; only latency differs.
- The macro must never change result or coprime values.

Test Plan:
- Reset: hold RST for 2 cycles -> ready=1, done=0, result=0, coprime=0.
- (12,18): start at E0 -> k=2, done at E0+4, result=6, coprime=0. Hold start high in RUN and check that it is ignored.
- (25534,3):
  - without macro: done at E0+8515, result=1, coprime=1.
  - with GCD_EARLY_ONE_EN: done at E0+8513, result=1.
- (25534,2): result=2, coprime=0, done at E0+12768.
- Zero and equal cases:
  - (0,0) -> result 0 at E0+2.
  - (0,9) -> result 9 at E0+2.
  - (7,7) -> result 7 at E0+2.
  - (1,40000) with macro -> result 1 at E0+2.
- Abort and back-to-back:
  - Assert RST 3 cycles into (25534,3) -> IDLE next edge, done stays 0.
  - Then start (12,18) in the cycle done rises for a prior (7,7) -> done drops, result 6 at +4.
